// File: rtl/slave_rx_fifo_if.sv
// slave_rx_fifo_if: the upstream and downstream valid/ready beat handshakes
// that are bundled for slave_rx_fifo.
`default_nettype none

interface slave_rx_fifo_if #(
    parameter int DW = 3
);
    logic          valid_up;
    logic [DW-1:0] data_up;
    logic          ready_up;
    logic          valid_out;
    logic [DW-1:0] data_out;
    logic          ready_in;

    modport master (
        output valid_up, data_up, ready_in,
        input  ready_up, valid_out, data_out
    );

    modport slave (
        input  valid_up, data_up, ready_in,
        output ready_up, valid_out, data_out
    );
endinterface

`default_nettype wire

// File: rtl/slave_rx_fifo.sv
// slave_rx_fifo: small synchronous FIFO between the bus master and the sink,
// with a beat counter and an optional pattern checker (SLAVE_RX_CHECK_EN).
`default_nettype none

module slave_rx_fifo #(
    parameter  int DW    = 3,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  wire logic        sys_clk,
    input  wire logic        sys_rst,
    slave_rx_fifo_if.slave   bus,
    output logic [AW:0]      level,
    output logic [7:0]       beat_cnt,
    output logic             err
);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // Handshake flags come only from registered occupancy.
    assign bus.ready_up  = (level != FULL_LVL);
    assign bus.valid_out = (level != '0);
    assign bus.data_out  = mem[rd_ptr];

    assign push = bus.valid_up  & bus.ready_up;
    assign pop  = bus.valid_out & bus.ready_in;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            beat_cnt <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= bus.data_up;
                wr_ptr      <= wr_ptr + 1'b1;
                beat_cnt    <= beat_cnt + 8'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

`ifdef SLAVE_RX_CHECK_EN
    typedef enum logic [1:0] {
        EXP0 = 2'd0,
        EXP1 = 2'd1,
        EXP2 = 2'd2
    } chk_state_t;

    chk_state_t state;
    chk_state_t state_nxt;
    chk_state_t state_adv;
    logic [2:0] exp_data;
    logic       err_nxt;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= EXP0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        state_adv = EXP0;
        exp_data  = 3'b111;
        err_nxt   = err;
        case (state)
            EXP0: begin
                exp_data  = 3'b111;
                state_adv = EXP1;
            end
            EXP1: begin
                exp_data  = 3'b101;
                state_adv = EXP2;
            end
            EXP2: begin
                exp_data  = 3'b110;
                state_adv = EXP0;
            end
            default: begin
                exp_data  = 3'b111;
                state_adv = EXP0;
            end
        endcase
        // An idle cycle means the master restarts its sequence; stalls hold.
        if (!bus.valid_up) begin
            state_nxt = EXP0;
        end else if (push) begin
            state_nxt = state_adv;
            if (bus.data_up[2:0] != exp_data) begin
                err_nxt = 1'b1;
            end
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_slave_rx_fifo.sv
// tb_slave_rx_fifo: directed self-checking bench for slave_rx_fifo.
`default_nettype none

module tb_slave_rx_fifo;
`ifdef SLAVE_RX_CHECK_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic [2:0] level;
    logic [7:0] beat_cnt;
    logic       err;

    int checks   = 0;
    int failures = 0;

    slave_rx_fifo_if #(.DW(3)) bus ();

    slave_rx_fifo dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .bus      (bus),
        .level    (level),
        .beat_cnt (beat_cnt),
        .err      (err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send(input logic [2:0] d);
        bus.valid_up = 1'b1;
        bus.data_up  = d;
        tick();
    endtask

    logic [2:0] q[$];
    logic [2:0] drain_exp [4];
    logic [2:0] pd;
    logic [2:0] wd;
    logic       do_push;
    logic       do_pop;
    int         pops;

    initial begin
        bus.valid_up = 1'b0;
        bus.data_up  = 3'b000;
        bus.ready_in = 1'b0;
        tick();
        tick();
        sys_rst = 1'b0;
        tick();

        // Reset state
        check("rst_ready_up", bus.ready_up, 1);
        check("rst_valid_out", bus.valid_out, 0);
        check("rst_level", level, 0);
        check("rst_beat_cnt", beat_cnt, 0);
        check("rst_err", err, 0);
        check("rst_data_out", bus.data_out, 0);

        // Pattern push with sink stalled, then drain
        bus.valid_up = 1'b1;
        bus.data_up  = 3'b111;
        #1;
        check("no_bypass", bus.valid_out, 0);
        tick();
        check("p1_level", level, 1);
        check("p1_valid_out", bus.valid_out, 1);
        check("p1_data_out", bus.data_out, 7);
        send(3'b101);
        check("p2_level", level, 2);
        send(3'b110);
        check("p3_level", level, 3);
        check("p3_ready_up", bus.ready_up, 1);
        bus.valid_up = 1'b0;
        bus.ready_in = 1'b1;
        check("d0_data_out", bus.data_out, 7);
        tick();
        check("d1_data_out", bus.data_out, 5);
        check("d1_level", level, 2);
        tick();
        check("d2_data_out", bus.data_out, 6);
        check("d2_level", level, 1);
        tick();
        check("d3_level", level, 0);
        check("d3_valid_out", bus.valid_out, 0);
        check("d3_beat_cnt", beat_cnt, 3);
        check("d3_err", err, 0);

        // Checker: correct sequence with wrap
        send(3'b111);
        send(3'b101);
        send(3'b110);
        send(3'b111);
        check("seq_ok_err", err, 0);
        bus.valid_up = 1'b0;
        tick();
        // Checker: idle mid-sequence restarts expectation
        send(3'b111);
        send(3'b101);
        bus.valid_up = 1'b0;
        tick();
        send(3'b111);
        check("restart_err", err, 0);
        bus.valid_up = 1'b0;
        tick();
        // Checker: mismatch is sticky
        send(3'b111);
        check("mis1_err", err, 0);
        send(3'b110);
        check("mis2_err", err, CHK);
        bus.valid_up = 1'b0;
        tick();
        tick();
        check("mis_sticky_err", err, CHK);
        check("chk_beat_cnt", beat_cnt, 12);
        check("chk_level", level, 0);

        // Asynchronous reset with level=3
        bus.ready_in = 1'b0;
        send(3'b001);
        send(3'b010);
        send(3'b011);
        check("pre_rst_level", level, 3);
        bus.valid_up = 1'b0;
        sys_rst = 1'b1;
        #1;
        check("arst_valid_out", bus.valid_out, 0);
        check("arst_level", level, 0);
        check("arst_ready_up", bus.ready_up, 1);
        check("arst_err", err, 0);
        check("arst_beat_cnt", beat_cnt, 0);
        check("arst_data_out", bus.data_out, 0);
        tick();
        sys_rst = 1'b0;
        tick();

        // Fill to full, fifth beat held upstream
        for (int k = 0; k < 4; k++) begin
            wd = 3'(k + 1);
            send(wd);
            check("fill_level", level, k + 1);
            check("fill_ready_up", bus.ready_up, (k < 3) ? 1 : 0);
        end
        send(3'b101);
        check("full_level", level, 4);
        check("full_ready_up", bus.ready_up, 0);
        check("full_beat_cnt", beat_cnt, 4);
        bus.ready_in = 1'b1;
        check("full_head", bus.data_out, 1);
        tick();
        check("pop_level", level, 3);
        check("pop_ready_up", bus.ready_up, 1);
        check("pop_beat_cnt", beat_cnt, 4);
        bus.ready_in = 1'b0;
        tick();
        check("held_level", level, 4);
        check("held_beat_cnt", beat_cnt, 5);
        check("full_err", err, CHK);
        bus.valid_up = 1'b0;
        bus.ready_in = 1'b1;
        drain_exp[0] = 3'd2;
        drain_exp[1] = 3'd3;
        drain_exp[2] = 3'd4;
        drain_exp[3] = 3'd5;
        for (int k = 0; k < 4; k++) begin
            check("full_drain", bus.data_out, drain_exp[k]);
            tick();
        end
        check("drained_valid_out", bus.valid_out, 0);

        // Sustained throughput from a fresh reset
        sys_rst = 1'b1;
        #1;
        sys_rst = 1'b0;
        tick();
        pops = 0;
        bus.valid_up = 1'b1;
        bus.ready_in = 1'b1;
        for (int i = 0; i < 300; i++) begin
            bus.data_up = 3'(i % 8);
            #1;
            do_push = bus.valid_up && bus.ready_up;
            do_pop  = bus.valid_out && bus.ready_in;
            pd      = bus.data_out;
            wd      = bus.data_up;
            tick();
            if (do_pop) begin
                pops++;
                if (q.size() == 0) check("thr_underflow", 1, 0);
                else check("thr_data", pd, q.pop_front());
            end
            if (do_push) q.push_back(wd);
            check("thr_level_le1", (level <= 3'd1) ? 1 : 0, 1);
        end
        check("thr_beat_cnt", beat_cnt, 44);
        bus.valid_up = 1'b0;
        #1;
        do_pop = bus.valid_out && bus.ready_in;
        pd     = bus.data_out;
        tick();
        if (do_pop) begin
            pops++;
            if (q.size() == 0) check("thr_underflow", 1, 0);
            else check("thr_data", pd, q.pop_front());
        end
        check("thr_pops", pops, 300);
        check("thr_queue_empty", q.size(), 0);
        check("thr_final_level", level, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
